// File: rtl/rot_arb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rot_arb_sequencer
// Purpose  : Round-robin arbiter and step sequencer sharing one external
//            8-bit combinational rotator between two requesters. A granted
//            request is rotated COUNT times by the same amount/direction
//            and the final word is returned on a valid/ready response port
//            tagged with the requester ID.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req{0,1}_valid/ready     - request handshake per requester
//            req{0,1}_data/amt/left/count - operand, step amount, direction,
//                                       number of steps
//            rsp_valid/ready, rsp_data, rsp_id - response handshake
//            rot_in/rot_sel/rot_left  - drive the external rotator
//            rot_out                  - external rotator result
//            busy                     - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module rot_arb_sequencer #(
    parameter int CNT_W = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [2:0]       req0_amt,
    input  logic             req0_left,
    input  logic [CNT_W-1:0] req0_count,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [2:0]       req1_amt,
    input  logic             req1_left,
    input  logic [CNT_W-1:0] req1_count,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,

    output logic [WIDTH-1:0] rot_in,
    output logic [2:0]       rot_sel,
    output logic             rot_left,
    input  logic [WIDTH-1:0] rot_out,

    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [2:0]       r_amt;
    logic             r_dir;
    logic [CNT_W-1:0] r_remaining;
    logic             r_id;
    logic             r_last_grant;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_id;

    logic             w_idle;
    logic             w_winner;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic [2:0]       w_sel_amt;
    logic             w_sel_left;
    logic [CNT_W-1:0] w_sel_count;

    assign w_idle = (r_state == S_IDLE);

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last_grant;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    assign req0_ready = w_idle && req0_valid && !w_winner;
    assign req1_ready = w_idle && req1_valid &&  w_winner;
    assign w_accept   = req0_ready || req1_ready;

    assign w_sel_data  = w_winner ? req1_data  : req0_data;
    assign w_sel_amt   = w_winner ? req1_amt   : req0_amt;
    assign w_sel_left  = w_winner ? req1_left  : req0_left;
    assign w_sel_count = w_winner ? req1_count : req0_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_amt        <= '0;
            r_dir        <= 1'b0;
            r_remaining  <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc        <= w_sel_data;
                        r_amt        <= w_sel_amt;
                        r_dir        <= w_sel_left;
                        r_remaining  <= w_sel_count;
                        r_id         <= w_winner;
                        r_last_grant <= w_winner;
                        if (w_sel_count == c_cnt_zero) begin
                            // Zero steps: the operand is the result.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_sel_data;
                            r_rsp_id    <= w_winner;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_acc       <= rot_out;
                    r_remaining <= r_remaining - c_cnt_one;
                    // Last step: capture the rotator output directly so the
                    // response is ready on the same edge.
                    if (r_remaining == c_cnt_one) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= rot_out;
                        r_rsp_id    <= r_id;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rot_in    = r_acc;
    assign rot_sel   = r_amt;
    assign rot_left  = r_dir;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rot_arb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot_arb_sequencer
// Purpose  : Self-checking bench for rot_arb_sequencer. Provides the external
//            rotator as a behavioural model, drives requests from a vector
//            table and hand-written sequences, and checks responses through
//            an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rot_arb_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [7:0]       req0_data = '0, req1_data = '0;
    logic [2:0]       req0_amt = '0, req1_amt = '0;
    logic             req0_left = 1'b0, req1_left = 1'b0;
    logic [CNT_W-1:0] req0_count = '0, req1_count = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [7:0]       rsp_data;
    logic             rsp_id;
    logic [7:0]       rot_in;
    logic [2:0]       rot_sel;
    logic             rot_left;
    logic [7:0]       rot_out;
    logic             busy;

    rot_arb_sequencer #(.CNT_W(CNT_W), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_left(req0_left), .req0_count(req0_count),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_left(req1_left), .req1_count(req1_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id),
        .rot_in(rot_in), .rot_sel(rot_sel), .rot_left(rot_left), .rot_out(rot_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External rotator model.
    function automatic logic [7:0] rot1(input logic [7:0] d, input logic [2:0] a, input logic l);
        logic [15:0] dd;
        logic [15:0] sh;
        dd = {d, d};
        if (l) begin
            sh = dd << a;
            return sh[15:8];
        end
        sh = dd >> a;
        return sh[7:0];
    endfunction

    function automatic logic [7:0] rotn(input logic [7:0] d, input logic [2:0] a,
                                        input logic l, input int n);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < n; i++) r = rot1(r, a, l);
        return r;
    endfunction

    assign rot_out = rot1(rot_in, rot_sel, rot_left);

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         lat;
    } exp_t;

    typedef struct {
        logic             port;
        logic [7:0]       data;
        logic [2:0]       amt;
        logic             left;
        logic [CNT_W-1:0] cnt;
        logic [7:0]       exp_data;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   lat_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (lat_pending && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL latency_no_expectation actual=rsp_valid required=none");
                end else begin
                    chk("latency", cyc - acc_cyc, exp_q[0].lat);
                end
                lat_pending = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_id", rsp_id, e.id);
                end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_cyc     = cyc;
                lat_pending = 1'b1;
            end
        end
    end

    task automatic drive(input logic p, input logic [7:0] d, input logic [2:0] a,
                         input logic l, input logic [CNT_W-1:0] c, input logic v);
        if (!p) begin
            req0_data = d; req0_amt = a; req0_left = l; req0_count = c; req0_valid = v;
        end else begin
            req1_data = d; req1_amt = a; req1_left = l; req1_count = c; req1_valid = v;
        end
    endtask

    task automatic push_exp(input logic id, input logic [7:0] d, input int lat);
        exp_t e;
        e.id = id; e.data = d; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic issue(input vec_t v, input bit push);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drive(v.port, v.data, v.amt, v.left, v.cnt, 1'b1);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((v.port == 1'b0 && req0_ready) || (v.port == 1'b1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=no_ready required=ready port=%0d", v.port);
        end else if (push) begin
            push_exp(v.port, v.exp_data, int'(v.cnt) + 1);
        end
        @(posedge clk); #1;
        drive(v.port, 8'h00, 3'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=pending%0d required=0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        lat_pending = 1'b0;
    endtask

    vec_t       vecs[7];
    logic [7:0] ad[2][4];
    logic [2:0] aa[2][4];
    logic       al[2][4];
    logic [3:0] ac[2][4];

    initial begin
        // port, data, amt, left, count, expected
        vecs[0] = '{1'b0, 8'h81, 3'd1, 1'b0, 4'd3,  8'h30};
        vecs[1] = '{1'b1, 8'h01, 3'd2, 1'b1, 4'd2,  8'h10};
        vecs[2] = '{1'b1, 8'hA5, 3'd3, 1'b1, 4'd0,  8'hA5};
        vecs[3] = '{1'b0, 8'h5A, 3'd0, 1'b1, 4'd15, 8'h5A};
        vecs[4] = '{1'b1, 8'h96, 3'd3, 1'b1, 4'd15, 8'hD2};
        vecs[5] = '{1'b0, 8'h3C, 3'd7, 1'b0, 4'd1,  8'h78};
        vecs[6] = '{1'b0, 8'h01, 3'd1, 1'b0, 4'd8,  8'h01};

        // Reset then idle.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready0", req0_ready, 0);
        chk("reset_ready1", req1_ready, 0);
        chk("reset_rot_in", rot_in, 0);
        chk("reset_rot_sel", rot_sel, 0);
        chk("reset_rot_left", rot_left, 0);

        // Table-driven single requests.
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i], 1'b1);
            wait_done();
        end

        // Both requesters continuously valid: grants alternate from 0.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                ad[p][k] = 8'($urandom);
                aa[p][k] = 3'($urandom);
                al[p][k] = 1'($urandom);
                ac[p][k] = 4'($urandom_range(0, 5));
            end
        end
        begin
            int  idx[2];
            int  got;
            logic g;
            logic w;
            idx[0] = 0; idx[1] = 0; got = 0; g = 1'b0;
            @(posedge clk); #1;
            drive(1'b0, ad[0][0], aa[0][0], al[0][0], ac[0][0], 1'b1);
            drive(1'b1, ad[1][0], aa[1][0], al[1][0], ac[1][0], 1'b1);
            for (int n = 0; n < 2000 && got < 8; n++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    chk("one_ready", req0_ready && req1_ready, 0);
                    w = req1_ready;
                    chk("grant_order", w, g);
                    g = ~g;
                    push_exp(w, rotn(ad[w][idx[w]], aa[w][idx[w]], al[w][idx[w]],
                                     int'(ac[w][idx[w]])), int'(ac[w][idx[w]]) + 1);
                    got++;
                    @(posedge clk); #1;
                    idx[w]++;
                    if (idx[w] == 4) drive(w, 8'h00, 3'd0, 1'b0, '0, 1'b0);
                    else drive(w, ad[w][idx[w]], aa[w][idx[w]], al[w][idx[w]],
                               ac[w][idx[w]], 1'b1);
                end
            end
            chk("arb_grants", got, 8);
            drive(1'b0, 8'h00, 3'd0, 1'b0, '0, 1'b0);
            drive(1'b1, 8'h00, 3'd0, 1'b0, '0, 1'b0);
            wait_done();
        end

        // Response backpressure for 7 cycles.
        rsp_ready = 1'b0;
        issue('{1'b0, 8'hC3, 3'd1, 1'b1, 4'd2, 8'h0F}, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 50; n++) begin
                if (rsp_valid) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            chk("bp_rsp_valid_seen", seen, 1);
        end
        @(posedge clk); #1;
        drive(1'b1, 8'h77, 3'd1, 1'b1, 4'd1, 1'b1);
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            chk("bp_rsp_data", rsp_data, 8'h0F);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_readys", req0_ready || req1_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        drive(1'b1, 8'h00, 3'd0, 1'b0, '0, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_rsp_valid", rsp_valid, 0);
        chk("bp_idle_rsp_data_kept", rsp_data, 8'h0F);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a long RUN.
        issue('{1'b0, 8'h55, 3'd1, 1'b1, 4'd10, 8'h00}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        lat_pending = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_rot_in", rot_in, 0);
        begin
            int hi;
            hi = 0;
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (rsp_valid) hi++;
            end
            chk("rst_mid_no_rsp", hi, 0);
        end
        issue('{1'b1, 8'h12, 3'd1, 1'b1, 4'd10, 8'h48}, 1'b1);
        wait_done();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rot_arb_sequencer.md
Name: rot_arb_sequencer

Overview:
- Controller that shares one 8-bit combinational rotator datapath between two requesters.
- Performs round-robin arbitration between the requesters, then sequences repeated rotations on the winning request: the same amount is applied COUNT times through the rotator.
- Returns the final word on a valid/ready response port, tagged with the requester ID.
- Sits between client logic and the single rotator instance. The rotator is external; this block drives its inputs and samples its output.

Parameters:
- CNT_W, 4, width of the per-request repeat count.
- WIDTH, 8, data width. Fixed at 8 to match the rotator; any other value is unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_data  input  8  operand.
- req0_amt  input  3  rotate amount per step.
- req0_left  input  1  1 = rotate left, 0 = rotate right.
- req0_count  input  CNT_W  number of rotate steps.
- req1_valid, req1_ready, req1_data, req1_amt, req1_left, req1_count  same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  8  rotated result.
- rsp_id  output  1  requester that issued the result.
- rot_in  output  8  to rotator data input; driven from the accumulator register.
- rot_sel  output  3  to rotator select input; the latched amount.
- rot_left  output  1  to rotator direction input; the latched direction.
- rot_out  input  8  rotator combinational result.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset values, on rst high at a clock edge:
  - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_id = 0.
  - acc, amt, dir and remaining = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - rst overrides everything, including mid-RUN or mid-RESP. The in-flight request is dropped and no response is issued.
- Arbitration (combinational, IDLE only):
  - Exactly one of req0_ready / req1_ready may be high.
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant the requester that is not last_grant.
  - reqN_ready = (state == IDLE) and (winner == N). Both readys are 0 outside IDLE.
- Accept, on a valid & ready edge:
  - Latch acc = data, amt, dir = left, remaining = count, id = winner.
  - last_grant = winner; the pointer updates on accept, not on response.
  - If count == 0, go to RESP. Otherwise go to RUN.
- RUN:
  - Each cycle: acc <= rot_out and remaining <= remaining − 1.
  - When remaining == 1 on the current edge, go to RESP, with rsp_data loaded with rot_out on the same edge.
  - RUN occupies exactly count cycles.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable until rsp_ready.
  - On the valid & ready edge go to IDLE. rsp_valid drops the next cycle and rsp_data keeps its last value.
  - Backpressure of any length is legal.
- Latency, from the accept edge to first rsp_valid high: count + 1 cycles. For count = 0 this is 1 cycle.
- Throughput: one request in flight. The next accept is possible in the cycle after the response handshake. No back-to-back overlap.
- rot_in, rot_sel and rot_left are always the registered acc, amt and dir. They are valid in every state, but only consumed in RUN.
- amt = 0 is legal: the data passes unchanged through all steps.
- count = 2^CNT_W − 1 (15) is legal: 15 RUN cycles, no overflow; remaining never wraps.
- Requests arriving outside IDLE are not accepted. ready stays 0 and the requester must hold valid and its fields.

Test Plan:
- Reset, then idle for 5 cycles → all outputs 0, busy = 0, both readys 0 with no valid.
- req0: data 0x81, amt 1, right, count 3 → accepted 1st cycle; rsp_valid 4 cycles after accept; rsp_data 0x30, rsp_id 0.
- req1: data 0x01, amt 2, left, count 2 → rsp_data 0x10, rsp_id 1, latency 3. Then data 0xA5, count 0 → rsp_data 0xA5, latency 1.
- Both valid continuously, 4 requests each → grants alternate 0,1,0,1…, starting with 0 after reset. Each response id matches its grant.
- Hold rsp_ready low for 7 cycles → rsp_data/rsp_id stable, both readys 0, busy 1. Raise rsp_ready → IDLE next cycle.
- Assert rst during RUN with count 10 → next cycle state is IDLE and rsp_valid 0. A fresh request then completes correctly.
